// File: rtl/fod_phe_lockdet.sv
// FOD phase-error decoder, saturating calibration accumulator and lock-detect FSM.
// Optional per-code histogram bins are built when FOD_PHE_HIST_EN is defined.
module fod_phe_lockdet #(
    parameter int WA         = 12,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_CNT = 4,
    parameter int CW         = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [7:0]    PSAMP,
    input  logic [2:0]    PHE_EXP,
    input  logic          ACC_CLR,
    output logic [2:0]    PHE,
    output logic [3:0]    PHE_ERR,
    output logic          PHE_VLD,
    output logic [WA-1:0] ACC,
    output logic          LOCK,
    output logic [1:0]    LOCK_ST,
    input  logic [2:0]    HIST_SEL,
    output logic [15:0]   HIST_DATA
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0]    TOL_L      = 4'(TOL);
    localparam logic [CW-1:0] LOCK_LIM   = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] UNLOCK_LIM = CW'(UNLOCK_CNT - 1);
    localparam logic [WA-1:0] ACC_MAX    = {1'b0, {(WA-1){1'b1}}};
    localparam logic [WA-1:0] ACC_MIN    = {1'b1, {(WA-1){1'b0}}};

    logic [2:0]    dec_code;
    logic          dec_vld;
    logic [2:0]    diff;
    logic [3:0]    err_mag;
    logic          intol;
    logic [WA:0]   acc_sum;
    logic [WA-1:0] acc_next;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;

    // A code is the lowest phase k whose bit is 1 with the next phase 0; phase 7 wraps to bit 0.
    always_comb begin
        dec_code = 3'd0;
        dec_vld  = 1'b0;
        if (PSAMP[7] && !PSAMP[0]) begin
            dec_code = 3'd7;
            dec_vld  = 1'b1;
        end
        for (int k = 6; k >= 0; k--) begin
            if (PSAMP[k] && !PSAMP[k+1]) begin
                dec_code = 3'(k);
                dec_vld  = 1'b1;
            end
        end
    end

    assign diff = dec_code - PHE_EXP;

    always_ff @(posedge CLK) begin
        if (RST) begin
            PHE     <= 3'd0;
            PHE_ERR <= 4'd0;
            PHE_VLD <= 1'b0;
        end else begin
            PHE_VLD <= dec_vld;
            if (dec_vld) begin
                PHE     <= dec_code;
                PHE_ERR <= {diff[2], diff};
            end else begin
                PHE_ERR <= 4'd0;
            end
        end
    end

    assign err_mag = PHE_ERR[3] ? (4'd0 - PHE_ERR) : PHE_ERR;
    assign intol   = PHE_VLD && (err_mag <= TOL_L);

    // One guard bit above the accumulator detects overflow; clamp instead of wrapping.
    always_comb begin
        acc_sum  = {ACC[WA-1], ACC} + {{(WA-3){PHE_ERR[3]}}, PHE_ERR};
        acc_next = acc_sum[WA-1:0];
        if (acc_sum[WA] != acc_sum[WA-1]) begin
            acc_next = acc_sum[WA] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ACC <= '0;
        end else if (ACC_CLR) begin
            ACC <= '0;
        end else if (EN && PHE_VLD) begin
            ACC <= acc_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!EN) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = ACQ;
                    cnt_nx   = '0;
                end
                ACQ: begin
                    if (!intol) begin
                        cnt_nx = '0;
                    end else if (cnt == LOCK_LIM) begin
                        state_nx = LOCKED;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                LOCKED: begin
                    if (!intol) begin
                        state_nx = HOLD;
                        cnt_nx   = CW'(1);
                    end else begin
                        cnt_nx = '0;
                    end
                end
                HOLD: begin
                    if (intol) begin
                        state_nx = LOCKED;
                        cnt_nx   = '0;
                    end else if (cnt == UNLOCK_LIM) begin
                        state_nx = ACQ;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign LOCK_ST = state;
    assign LOCK    = (state == LOCKED) || (state == HOLD);

`ifdef FOD_PHE_HIST_EN
    logic [15:0] bins [8];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 8; i++) begin
                bins[i] <= 16'd0;
            end
        end else if (EN && PHE_VLD && (bins[PHE] != 16'hFFFF)) begin
            bins[PHE] <= bins[PHE] + 16'd1;
        end
    end

    assign HIST_DATA = bins[HIST_SEL];
`else
    logic unused_hist_sel;
    assign unused_hist_sel = ^HIST_SEL;
    assign HIST_DATA       = 16'd0;
`endif

endmodule
